// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the PikaRISC data memory controller.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic {StInit, StReady} state_e;

    // Natural alignment check only; illegal size and range are flagged by the caller.
    function automatic logic align_err(input logic [1:0] size, input logic [1:0] lane);
        return ((size == SZ_HALF) && lane[0]) || ((size == SZ_WORD) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables/positioned data and load extraction/extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        is_unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_lane_o,
    output logic [31:0] rdata_ext_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_o         = 4'b0000;
        wdata_lane_o = '0;
        rdata_ext_o  = '0;
        byte_sel     = rword_i[{lane_i, 3'b000} +: 8];
        half_sel     = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
        case (size_i)
            SZ_BYTE: begin
                be_o         = 4'b0001 << lane_i;
                wdata_lane_o = {4{wdata_i[7:0]}};
                rdata_ext_o  = {{24{~is_unsigned_i & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be_o         = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_lane_o = {2{wdata_i[15:0]}};
                rdata_ext_o  = {{16{~is_unsigned_i & half_sel[15]}}, half_sel};
            end
            SZ_WORD: begin
                be_o         = 4'b1111;
                wdata_lane_o = wdata_i;
                rdata_ext_o  = rword_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory with post-reset clear sweep and one-cycle response.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error,
    output logic                  init_busy
);

    localparam int unsigned IdxW = $clog2(DEPTH);

    logic [31:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic              req_ready_q, req_ready_d;
    logic              init_busy_q, init_busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;

    logic [1:0]        lane;
    logic [IdxW-1:0]   idx;
    logic              out_of_range;
    logic              req_err;
    logic              accept;
    logic [3:0]        be;
    logic [31:0]       wdata_lane;
    logic [31:0]       rdata_ext;

    assign lane         = req_addr[1:0];
    assign idx          = req_addr[IdxW+1:2];
    assign out_of_range = |(req_addr >> (IdxW + 2));
    assign req_err      = (req_size == SZ_ILL) || align_err(req_size, lane) || out_of_range;
    assign accept       = req_valid && req_ready_q;

    dmem_lane_align u_lane_align (
        .size_i        (req_size),
        .lane_i        (lane),
        .is_unsigned_i (req_unsigned),
        .wdata_i       (req_wdata),
        .rword_i       (mem_q[idx]),
        .be_o          (be),
        .wdata_lane_o  (wdata_lane),
        .rdata_ext_o   (rdata_ext)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        req_ready_d = req_ready_q;
        init_busy_d = init_busy_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_error_d = 1'b0;
        case (state_q)
            StInit: begin
                if (!CLEAR_ON_RESET || (ptr_q == IdxW'(DEPTH - 1))) begin
                    state_d     = StReady;
                    req_ready_d = 1'b1;
                    init_busy_d = 1'b0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            StReady: begin
                if (accept) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = req_err;
                    rsp_rdata_d = (req_err || req_write) ? 32'h0 : rdata_ext;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StInit;
            ptr_q       <= '0;
            req_ready_q <= 1'b0;
            init_busy_q <= CLEAR_ON_RESET;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            req_ready_q <= req_ready_d;
            init_busy_q <= init_busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // Array has no reset; the sweep (or a store) is the only writer.
    always_ff @(posedge clk) begin
        if (CLEAR_ON_RESET && (state_q == StInit)) begin
            mem_q[ptr_q] <= '0;
        end else if (accept && req_write && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
        end
    end

    assign req_ready = req_ready_q;
    assign init_busy = init_busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl with DEPTH=16 and directed load/store vectors.
module tb_data_mem_ctrl;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        init_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    data_mem_ctrl #(
        .DEPTH          (16),
        .ADDR_WIDTH     (32),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .init_busy    (init_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Monitor: every presented response must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rsp_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: rdata=%08h err=%0b, required no response",
                         rsp_rdata, rsp_error);
            end else begin
                e = sb_q.pop_front();
                if (rsp_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL %s rdata: got %08h, required %08h", e.name, rsp_rdata,
                             e.rdata);
                end
                checks++;
                if (rsp_error !== e.err) begin
                    errors++;
                    $display("FAIL %s error: got %0b, required %0b", e.name, rsp_error, e.err);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic issue(input string name, input logic wr, input logic [31:0] addr,
                         input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        check({name, " ready"}, {31'b0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_addr     = addr;
        req_size     = sz;
        req_unsigned = uns;
        req_wdata    = wd;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.name  = name;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after reset release; counts edges until req_ready rises.
    task automatic wait_init(input string name);
        int n = 0;
        bit bad = 1'b0;
        while (!req_ready && n < 100) begin
            if (!init_busy) bad = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " init_cycles"}, n, 32'd16);
        check({name, " busy_during_init"}, {31'b0, bad}, 32'd0);
        check({name, " busy_after_init"}, {31'b0, init_busy}, 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = '0;
        req_size     = W;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        for (int i = 0; i < 16; i++) dut.mem_q[i] <= 32'hA5A5_0000 | 32'(i);
        idle(3);
        check("rst req_ready", {31'b0, req_ready}, 32'd0);
        check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'd0);
        check("rst rsp_error", {31'b0, rsp_error}, 32'd0);
        check("rst init_busy", {31'b0, init_busy}, 32'd1);
        reset = 1'b0;
        wait_init("boot");

        for (int a = 0; a < 64; a += 4) issue("clear_word", 1'b0, 32'(a), W, 1'b0, 0, 0, 1'b0);

        issue("st_w_8", 1'b1, 32'h8, W, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
        issue("ld_b_8", 1'b0, 32'h8, B, 1'b0, 0, 32'hFFFFFFEF, 1'b0);
        issue("ld_b_9", 1'b0, 32'h9, B, 1'b0, 0, 32'hFFFFFFBE, 1'b0);
        issue("ld_b_a", 1'b0, 32'hA, B, 1'b0, 0, 32'hFFFFFFAD, 1'b0);
        issue("ld_b_b", 1'b0, 32'hB, B, 1'b0, 0, 32'hFFFFFFDE, 1'b0);
        issue("ld_bu_b", 1'b0, 32'hB, B, 1'b1, 0, 32'h000000DE, 1'b0);
        issue("ld_hu_a", 1'b0, 32'hA, H, 1'b1, 0, 32'h0000DEAD, 1'b0);

        issue("st_w_4", 1'b1, 32'h4, W, 1'b0, 32'hAAAAAAAA, 32'h0, 1'b0);
        issue("st_h_6", 1'b1, 32'h6, H, 1'b1, 32'hFFFF1234, 32'h0, 1'b0);
        issue("ld_w_4", 1'b0, 32'h4, W, 1'b1, 0, 32'h1234AAAA, 1'b0);
        issue("ld_h_6", 1'b0, 32'h6, H, 1'b0, 0, 32'h00001234, 1'b0);
        issue("ld_h_4", 1'b0, 32'h4, H, 1'b0, 0, 32'hFFFFAAAA, 1'b0);
        issue("ld_hu_4", 1'b0, 32'h4, H, 1'b1, 0, 32'h0000AAAA, 1'b0);
        issue("st_b_f", 1'b1, 32'hF, B, 1'b0, 32'h000001FF, 32'h0, 1'b0);
        issue("ld_w_c", 1'b0, 32'hC, W, 1'b0, 0, 32'hFF000000, 1'b0);

        issue("st_h_9_mis", 1'b1, 32'h9, H, 1'b0, 32'h0000BEEF, 32'h0, 1'b1);
        issue("ld_w_8_keep", 1'b0, 32'h8, W, 1'b0, 0, 32'hDEADBEEF, 1'b0);
        issue("ld_w_a_mis", 1'b0, 32'hA, W, 1'b0, 0, 32'h0, 1'b1);
        issue("ld_w_2_mis", 1'b0, 32'h2, W, 1'b0, 0, 32'h0, 1'b1);
        issue("ld_sz11", 1'b0, 32'h8, X, 1'b0, 0, 32'h0, 1'b1);
        issue("st_sz11", 1'b1, 32'h8, X, 1'b0, 32'h11223344, 32'h0, 1'b1);
        issue("ld_w_40_oor", 1'b0, 32'h40, W, 1'b0, 0, 32'h0, 1'b1);
        issue("st_w_40_oor", 1'b1, 32'h40, W, 1'b0, 32'hCAFEF00D, 32'h0, 1'b1);
        issue("ld_w_0_keep", 1'b0, 32'h0, W, 1'b0, 0, 32'h0, 1'b0);
        issue("ld_hi_oor", 1'b0, 32'h80000008, W, 1'b0, 0, 32'h0, 1'b1);
        issue("ld_w_8_keep2", 1'b0, 32'h8, W, 1'b0, 0, 32'hDEADBEEF, 1'b0);
        idle(2);

        issue("b2b_st", 1'b1, 32'h10, B, 1'b0, 32'h00000055, 32'h0, 1'b0);
        check("b2b valid1", {31'b0, rsp_valid}, 32'd1);
        issue("b2b_ld", 1'b0, 32'h10, B, 1'b0, 0, 32'h00000055, 1'b0);
        check("b2b valid2", {31'b0, rsp_valid}, 32'd1);
        idle(2);

        // Accept a load, then reset before its response reaches the monitor.
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_addr     = 32'h10;
        req_size     = B;
        req_unsigned = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("inflight valid", {31'b0, rsp_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst drop valid", {31'b0, rsp_valid}, 32'd0);
        check("rst2 ready", {31'b0, req_ready}, 32'd0);
        check("rst2 busy", {31'b0, init_busy}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_init("reinit");
        issue("post_rst_b_10", 1'b0, 32'h10, B, 1'b1, 0, 32'h0, 1'b0);
        issue("post_rst_w_8", 1'b0, 32'h8, W, 1'b0, 0, 32'h0, 1'b0);
        idle(3);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
